lcd_read_engine: RTL and testbench
==================================

Name: lcd_read_engine

Overview:
- Read-side companion to the LCD power-on/write controller on the Spartan-3E board.
- Performs 4-bit HD44780-style read cycles (R/W=1) on SF_D<11:8>. Returns either the busy flag plus address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1).
- Optional busy-poll mode repeats status reads until BF=0 or a timeout expires. Write paths use this to replace fixed delays with busy-flag polling.
- Sits beside the write controller. The top level muxes shared LCD pins using oLCD_BusRelease.

Parameters:
- SETUP_CYCLES, 2: cycles of RS/RW setup before E rises, and hold after E falls (40 ns at 50 MHz).
- ENABLE_HIGH_CYCLES, 12: E high width per nibble. Data is sampled on the last high cycle.
- NIBBLE_GAP_CYCLES, 50: E low time between the upper and lower nibble (1 us).
- POLL_TIMEOUT, 100000: maximum cycles spent polling, measured from start accept (2 ms).

Ports:
- Clock, input, 1: 50 MHz system clock.
- Reset, input, 1: asynchronous, active-high reset.
- iRead_Start, input, 1: request. Sampled only in IDLE; ignored while oBusy=1.
- iRegisterSelect, input, 1: 0 = status read, 1 = data read. Latched at accept.
- iPoll_Busy, input, 1: 1 = repeat status reads until BF=0. Latched at accept; honoured only when RS=0.
- iLCD_Data, input, 4: SF_D<11:8> as returned by the LCD.
- oLCD_Enabled, output, 1: LCD_E.
- oLCD_RegisterSelect, output, 1: LCD_RS.
- oLCD_ReadWrite, output, 1: LCD_RW.
- oLCD_StrataFlashControl, output, 1: constant 1.
- oLCD_BusRelease, output, 1: 1 = the top level must tristate its SF_D drivers and route these pins to this block.
- oBusy, output, 1: high from the cycle after accept until the cycle after DONE.
- oRead_Data, output, 8: last completed byte, {upper, lower} nibble.
- oRead_Valid, output, 1: one-cycle pulse when oRead_Data updates.
- oTimeout, output, 1: one-cycle pulse, coincident with oRead_Valid, when polling gave up.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - State = IDLE.
  - oLCD_Enabled, oLCD_ReadWrite, oLCD_RegisterSelect, oLCD_BusRelease, oBusy, oRead_Valid, oTimeout = 0; oRead_Data = 8'h00.
  - Both counters = 0. oLCD_StrataFlashControl = 1 at all times.
- One 32-bit phase counter, cleared on every state change. One 32-bit poll counter, cleared at accept and incremented every non-IDLE cycle.
- States and outputs:
  - IDLE: E=0, RW=0, release=0. iRead_Start=1 latches RS and poll mode -> SETUP.
  - SETUP: RW=1, RS=latched, release=1, E=0. Stays SETUP_CYCLES cycles -> EHI_U.
  - EHI_U: E=1 for ENABLE_HIGH_CYCLES. On the last cycle, register iLCD_Data into upper[3:0] -> GAP.
  - GAP: E=0 for NIBBLE_GAP_CYCLES -> EHI_L.
  - EHI_L: E=1. Sample lower[3:0] on the last cycle -> HOLD.
  - HOLD: E=0, RW=1, release=1 for SETUP_CYCLES -> DONE.
  - DONE: one cycle, E=0, RW=1, release=1.
    - Poll mode with upper[3]=1 and poll counter < POLL_TIMEOUT: no valid pulse -> GAP_POLL.
    - Poll mode with upper[3]=1 and poll counter >= POLL_TIMEOUT: oRead_Data <= {upper,lower}, oRead_Valid=1, oTimeout=1 -> IDLE.
    - Otherwise: oRead_Data <= {upper,lower}, oRead_Valid=1 -> IDLE.
  - GAP_POLL: E=0, release=1 for NIBBLE_GAP_CYCLES -> SETUP.
- Latency, non-poll, defaults: start sampled at edge 0; oRead_Valid high in cycle 2*SETUP + 2*ENABLE + GAP + 1 = 79.
- E never rises while RW=0.
- RW returns to 0 and release to 0 in the cycle after DONE.
- oRead_Data holds its value until the next valid pulse.

Test Plan:
- Data read: RS=1, iLCD_Data = 4'hA during EHI_U and 4'h5 during EHI_L -> oRead_Data=8'hA5 and oRead_Valid in cycle 79. E is high exactly cycles 3-14 and 65-76. RW=1 over cycles 1-79.
- Status read without poll: RS=0, iPoll_Busy=0, nibbles 4'h8 then 4'h3 -> single read, oRead_Data=8'h83, no timeout.
- Busy poll: RS=0, iPoll_Busy=1, BF=1 for the first 3 reads then 4'h0/4'h7 -> exactly 4 E-pair sequences, one oRead_Valid with 8'h07, oTimeout=0.
- Timeout: POLL_TIMEOUT=500, BF held at 1 -> oRead_Valid and oTimeout pulse together at the first DONE where the poll counter >= 500. oRead_Data[7]=1. Back to IDLE.
- Reset mid-read: assert Reset during EHI_U -> E, RW, release and oBusy drop without waiting for a clock edge. oRead_Data=8'h00. A new start after Reset releases gives a normal 79-cycle read.
- iRead_Start held high during a read is ignored; a start on the cycle after DONE is accepted -> back-to-back reads separated by one IDLE cycle.

Source files
------------

// File: rtl/lcd_read_engine_if.sv
// Purpose : request/response and LCD pin bundle for the HD44780 4-bit read engine.
// Latency : none (wires only).
// Backpressure : none; the engine ignores iRead_Start while oBusy is high.
//
// Ports (slave = engine side):
//   iRead_Start, iRegisterSelect, iPoll_Busy : read request, RS select, busy-poll mode
//   iLCD_Data[3:0]                           : SF_D<11:8> as returned by the LCD
//   oLCD_Enabled/RegisterSelect/ReadWrite    : LCD_E / LCD_RS / LCD_RW
//   oLCD_StrataFlashControl                  : tied high so the StrataFlash stays off the bus
//   oLCD_BusRelease                          : top level must tristate SF_D and route pins here
//   oBusy, oRead_Data[7:0], oRead_Valid, oTimeout : status and result
interface lcd_read_engine_if;
  logic       iRead_Start;
  logic       iRegisterSelect;
  logic       iPoll_Busy;
  logic [3:0] iLCD_Data;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic       oLCD_ReadWrite;
  logic       oLCD_StrataFlashControl;
  logic       oLCD_BusRelease;
  logic       oBusy;
  logic [7:0] oRead_Data;
  logic       oRead_Valid;
  logic       oTimeout;

  modport slave (
    input  iRead_Start, iRegisterSelect, iPoll_Busy, iLCD_Data,
    output oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl,
    output oLCD_BusRelease, oBusy, oRead_Data, oRead_Valid, oTimeout
  );

  modport master (
    output iRead_Start, iRegisterSelect, iPoll_Busy, iLCD_Data,
    input  oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl,
    input  oLCD_BusRelease, oBusy, oRead_Data, oRead_Valid, oTimeout
  );
endinterface

// File: rtl/lcd_read_engine.sv
// Purpose : 4-bit HD44780 read cycles (status or data), with optional busy-flag polling.
// Latency : result valid 2*SETUP + 2*ENABLE + GAP + 1 cycles after accept (79 at defaults).
// Backpressure : single outstanding read; starts are ignored while oBusy is high.
//
// Ports: Clock, Reset (async, active high), lcdBus (lcd_read_engine_if.slave).
// All LCD pin outputs are registered so E/RW/RS/release are glitch-free.
module lcd_read_engine #(
  parameter int SETUP_CYCLES       = 2,
  parameter int ENABLE_HIGH_CYCLES = 12,
  parameter int NIBBLE_GAP_CYCLES  = 50,
  parameter int POLL_TIMEOUT       = 100000
) (
  input  logic             Clock,
  input  logic             Reset,
  lcd_read_engine_if.slave lcdBus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EHI_U,
    GAP,
    EHI_L,
    HOLD,
    DONE,
    GAP_POLL
  } state_t;

  localparam logic [31:0] SetupLast  = 32'(SETUP_CYCLES - 1);
  localparam logic [31:0] EnableLast = 32'(ENABLE_HIGH_CYCLES - 1);
  localparam logic [31:0] GapLast    = 32'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [31:0] PollLimit  = 32'(POLL_TIMEOUT);

  state_t      state;
  state_t      nextState;
  logic [31:0] phaseCnt;
  logic [31:0] pollCnt;
  logic [31:0] pollAtDone;
  logic        rsLatched;
  logic        pollLatched;
  logic        pollAgain;
  logic        pollMode;
  logic        busyFlagSet;
  logic        nextRs;
  logic [3:0]  upperNib;
  logic [3:0]  lowerNib;

  assign lcdBus.oLCD_StrataFlashControl = 1'b1;

  // Polling only makes sense for status reads; a data read never loops.
  assign pollMode    = pollLatched & ~rsLatched;
  assign busyFlagSet = upperNib[3];
  // The retry decision is taken on the HOLD->DONE edge so the result and
  // its valid pulse can appear in the DONE cycle itself; the poll counter
  // value that DONE will show is therefore one ahead of the current one.
  assign pollAtDone  = pollCnt + 32'd1;
  // RS for the next cycle: the request's RS on accept, else the latched one.
  assign nextRs      = (state == IDLE) ? lcdBus.iRegisterSelect : rsLatched;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (lcdBus.iRead_Start)    nextState = SETUP;
      SETUP:    if (phaseCnt == SetupLast)  nextState = EHI_U;
      EHI_U:    if (phaseCnt == EnableLast) nextState = GAP;
      GAP:      if (phaseCnt == GapLast)    nextState = EHI_L;
      EHI_L:    if (phaseCnt == EnableLast) nextState = HOLD;
      HOLD:     if (phaseCnt == SetupLast)  nextState = DONE;
      DONE:     nextState = pollAgain ? GAP_POLL : IDLE;
      GAP_POLL: if (phaseCnt == GapLast)    nextState = SETUP;
      default:  nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state                      <= IDLE;
      phaseCnt                   <= '0;
      pollCnt                    <= '0;
      rsLatched                  <= 1'b0;
      pollLatched                <= 1'b0;
      pollAgain                  <= 1'b0;
      upperNib                   <= 4'h0;
      lowerNib                   <= 4'h0;
      lcdBus.oLCD_Enabled        <= 1'b0;
      lcdBus.oLCD_RegisterSelect <= 1'b0;
      lcdBus.oLCD_ReadWrite      <= 1'b0;
      lcdBus.oLCD_BusRelease     <= 1'b0;
      lcdBus.oBusy               <= 1'b0;
      lcdBus.oRead_Data          <= 8'h00;
      lcdBus.oRead_Valid         <= 1'b0;
      lcdBus.oTimeout            <= 1'b0;
    end else begin
      lcdBus.oRead_Valid <= 1'b0;
      lcdBus.oTimeout    <= 1'b0;

      if (state != IDLE) pollCnt <= pollCnt + 32'd1;

      case (state)
        IDLE: begin
          if (lcdBus.iRead_Start) begin
            rsLatched   <= lcdBus.iRegisterSelect;
            pollLatched <= lcdBus.iPoll_Busy;
            pollCnt     <= '0;
          end
        end
        EHI_U: if (phaseCnt == EnableLast) upperNib <= lcdBus.iLCD_Data;
        EHI_L: if (phaseCnt == EnableLast) lowerNib <= lcdBus.iLCD_Data;
        HOLD: begin
          if (phaseCnt == SetupLast) begin
            if (pollMode && busyFlagSet && (pollAtDone < PollLimit)) begin
              pollAgain <= 1'b1;
            end else begin
              pollAgain          <= 1'b0;
              lcdBus.oRead_Data  <= {upperNib, lowerNib};
              lcdBus.oRead_Valid <= 1'b1;
              lcdBus.oTimeout    <= pollMode && busyFlagSet;
            end
          end
        end
        default: ;
      endcase

      state    <= nextState;
      phaseCnt <= ((nextState != state) || (state == IDLE)) ? 32'd0 : phaseCnt + 32'd1;

      // Pin outputs follow the state being entered, so they are registered
      // yet line up exactly with the state cycles. RW is high in every
      // non-IDLE state, which guarantees E can never rise with RW low.
      lcdBus.oLCD_Enabled        <= (nextState == EHI_U) || (nextState == EHI_L);
      lcdBus.oLCD_ReadWrite      <= (nextState != IDLE);
      lcdBus.oLCD_BusRelease     <= (nextState != IDLE);
      lcdBus.oBusy               <= (nextState != IDLE);
      lcdBus.oLCD_RegisterSelect <= (nextState != IDLE) ? nextRs : 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_read_engine.sv
// Purpose : scoreboard bench for lcd_read_engine with a behavioural LCD nibble source.
// Latency : expected result cycle is pushed at accept and checked when oRead_Valid fires.
// Backpressure : the stimulus waits for the engine to return to idle between reads.
module tb_lcd_read_engine;
  localparam int TO = 500;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  lcd_read_engine_if bus();

  lcd_read_engine #(
    .SETUP_CYCLES(2),
    .ENABLE_HIGH_CYCLES(12),
    .NIBBLE_GAP_CYCLES(50),
    .POLL_TIMEOUT(TO)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .lcdBus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         at;
  } exp_t;
  exp_t expQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // LCD model: presents the current nibble while E is high (its complement
  // while E is low) and steps to the next nibble on every E falling edge.
  logic [3:0] nib [16];
  logic [3:0] nibIdx = 4'd0;
  int         ePulses = 0;
  logic       prevE = 1'b0;
  initial forever begin
    @(negedge Clock);
    if (prevE && !bus.oLCD_Enabled) nibIdx++;
    if (!prevE && bus.oLCD_Enabled) ePulses++;
    prevE = bus.oLCD_Enabled;
    bus.iLCD_Data = bus.oLCD_Enabled ? nib[nibIdx] : ~nib[nibIdx];
  end

  // Monitor: compares every result pulse against the scoreboard head.
  initial forever begin
    @(negedge Clock);
    #1;
    if (bus.oLCD_Enabled) check("e_with_rw_low", bus.oLCD_ReadWrite, 1'b1);
    if (bus.oRead_Valid) begin
      if (expQ.size() == 0) begin
        check("valid_unexpected", bus.oRead_Valid, 1'b0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("rd_data", bus.oRead_Data, e.data);
        check("rd_timeout", bus.oTimeout, e.to);
        check("rd_cycle", cyc, e.at);
      end
    end else if (bus.oTimeout) begin
      check("timeout_without_valid", bus.oTimeout, bus.oRead_Valid);
    end
  end

  task automatic setNib(input int k, input logic [3:0] v);
    nib[4'(nibIdx + 4'(k))] = v;
  endtask

  // Issues a one-cycle start; returns at the negedge of relative cycle 1.
  task automatic startRead(input logic rs, input logic poll, input bit push,
                           input logic [7:0] d, input logic to, input int lat,
                           output int acc);
    @(negedge Clock);
    bus.iRegisterSelect = rs;
    bus.iPoll_Busy      = poll;
    bus.iRead_Start     = 1'b1;
    acc = cyc + 1;
    @(negedge Clock);
    bus.iRead_Start = 1'b0;
    if (push) expQ.push_back('{d, to, acc + lat - 1});
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (n < budget && (expQ.size() != 0 || bus.oBusy)) begin
      @(negedge Clock);
      #2;
      n++;
    end
    check("drain_budget", expQ.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, p0, errE, errRW, errRel, n;
    logic expE, expRW;
    Reset = 1'b1;
    bus.iRead_Start = 1'b0;
    bus.iRegisterSelect = 1'b0;
    bus.iPoll_Busy = 1'b0;
    for (int i = 0; i < 16; i++) nib[i] = 4'h0;

    // Reset state
    #12;
    check("rst_e", bus.oLCD_Enabled, 1'b0);
    check("rst_rw", bus.oLCD_ReadWrite, 1'b0);
    check("rst_rs", bus.oLCD_RegisterSelect, 1'b0);
    check("rst_release", bus.oLCD_BusRelease, 1'b0);
    check("rst_busy", bus.oBusy, 1'b0);
    check("rst_valid", bus.oRead_Valid, 1'b0);
    check("rst_timeout", bus.oTimeout, 1'b0);
    check("rst_data", bus.oRead_Data, 8'h00);
    check("rst_sf_ce", bus.oLCD_StrataFlashControl, 1'b1);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    // Data read with exact pin timing
    setNib(0, 4'hA); setNib(1, 4'h5);
    p0 = ePulses;
    startRead(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 79, acc);
    errE = 0; errRW = 0; errRel = 0;
    for (int r = 1; r <= 80; r++) begin
      #2;
      expE  = ((r >= 3 && r <= 14) || (r >= 65 && r <= 76));
      expRW = (r <= 79);
      if (bus.oLCD_Enabled !== expE) errE++;
      if (bus.oLCD_ReadWrite !== expRW) errRW++;
      if (bus.oLCD_BusRelease !== expRW) errRel++;
      if (r == 40) check("data_rs_high", bus.oLCD_RegisterSelect, 1'b1);
      if (r < 80) @(negedge Clock);
    end
    check("data_e_window_errs", errE, 0);
    check("data_rw_window_errs", errRW, 0);
    check("data_release_window_errs", errRel, 0);
    check("data_busy_after_done", bus.oBusy, 1'b0);
    check("data_e_pulses", ePulses - p0, 2);
    waitIdle(50);

    // Status read, no polling, BF set but ignored
    repeat (2) @(negedge Clock);
    setNib(0, 4'h8); setNib(1, 4'h3);
    p0 = ePulses;
    startRead(1'b0, 1'b0, 1'b1, 8'h83, 1'b0, 79, acc);
    waitIdle(200);
    check("status_e_pulses", ePulses - p0, 2);

    // Busy poll: BF=1 for three reads, then clear
    repeat (2) @(negedge Clock);
    setNib(0, 4'h8); setNib(1, 4'h1);
    setNib(2, 4'h9); setNib(3, 4'h2);
    setNib(4, 4'h8); setNib(5, 4'h3);
    setNib(6, 4'h0); setNib(7, 4'h7);
    p0 = ePulses;
    startRead(1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 79 + 3 * 129, acc);
    waitIdle(1000);
    check("poll_e_pulses", ePulses - p0, 8);

    // Poll timeout: BF never clears; DONE poll counts 78,207,336,465,594
    repeat (2) @(negedge Clock);
    setNib(0, 4'h8); setNib(1, 4'h1);
    setNib(2, 4'h9); setNib(3, 4'h2);
    setNib(4, 4'hA); setNib(5, 4'h3);
    setNib(6, 4'hB); setNib(7, 4'h4);
    setNib(8, 4'hC); setNib(9, 4'h5);
    p0 = ePulses;
    startRead(1'b0, 1'b1, 1'b1, 8'hC5, 1'b1, 79 + 4 * 129, acc);
    waitIdle(1200);
    check("timeout_e_pulses", ePulses - p0, 10);
    check("timeout_back_idle", bus.oLCD_BusRelease, 1'b0);

    // Asynchronous reset in the middle of the upper-nibble enable
    repeat (2) @(negedge Clock);
    setNib(0, 4'h6); setNib(1, 4'h6);
    startRead(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 79, acc);
    repeat (5) @(negedge Clock);
    #1;
    check("mid_e_high_before_reset", bus.oLCD_Enabled, 1'b1);
    Reset = 1'b1;
    #1;
    check("mid_rst_e", bus.oLCD_Enabled, 1'b0);
    check("mid_rst_rw", bus.oLCD_ReadWrite, 1'b0);
    check("mid_rst_release", bus.oLCD_BusRelease, 1'b0);
    check("mid_rst_busy", bus.oBusy, 1'b0);
    check("mid_rst_data", bus.oRead_Data, 8'h00);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    setNib(0, 4'h3); setNib(1, 4'hC);
    startRead(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 79, acc);
    waitIdle(200);

    // Start held high: ignored while busy, accepted right after DONE
    repeat (2) @(negedge Clock);
    setNib(0, 4'h1); setNib(1, 4'h2); setNib(2, 4'h4); setNib(3, 4'h8);
    p0 = ePulses;
    @(negedge Clock);
    bus.iRegisterSelect = 1'b1;
    bus.iPoll_Busy = 1'b0;
    bus.iRead_Start = 1'b1;
    acc = cyc + 1;
    expQ.push_back('{8'h12, 1'b0, acc + 78});
    expQ.push_back('{8'h48, 1'b0, acc + 80 + 78});
    n = 0;
    while (cyc != acc + 79 && n < 300) begin
      @(negedge Clock);
      n++;
    end
    #2;
    check("b2b_idle_cycle_busy", bus.oBusy, 1'b0);
    check("b2b_idle_cycle_rw", bus.oLCD_ReadWrite, 1'b0);
    @(negedge Clock);
    bus.iRead_Start = 1'b0;
    #2;
    check("b2b_second_accept_busy", bus.oBusy, 1'b1);
    waitIdle(300);
    check("b2b_e_pulses", ePulses - p0, 4);

    repeat (3) @(negedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
